// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: sequences RV32M DIV/DIVU/REM/REMU between EX and an iterative
// divider core. Divide-by-zero and signed overflow are resolved locally. All
// other ops launch the core, which is guarded by a watchdog. The selected
// result is returned with its destination tag.
//
// Optional feature: define DIV_RESULT_CACHE_EN to keep the last core result so
// that a matching DIV/REM pair (same operands and signedness) skips the core.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   in_valid/in_ready              op handshake (ready only in IDLE)
//   in_op, in_rs1, in_rs2, in_rd   funct3[1:0], dividend, divisor, dest tag
//   flush                          abort in-flight op, drop its result
//   div_start, div_kill            one-cycle launch / abort pulses to the core
//   div_dividend, div_divisor      core operands, held while BUSY
//   div_is_unsign                  1 for DIVU/REMU
//   div_done, div_quotient,
//   div_remainder                  core completion pulse and results
//   out_valid/out_ready            result handshake
//   out_data, out_rd, out_err      result, dest tag, watchdog-timeout flag
module div_issue_ctrl #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned DIV_TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_op,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [4:0]      in_rd,
   input  logic            flush,
   output logic            div_start,
   output logic [XLEN-1:0] div_dividend,
   output logic [XLEN-1:0] div_divisor,
   output logic            div_is_unsign,
   input  logic            div_done,
   input  logic [XLEN-1:0] div_quotient,
   input  logic [XLEN-1:0] div_remainder,
   output logic            div_kill,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic [4:0]      out_rd,
   output logic            out_err
);

   localparam int unsigned CNT_W = $clog2(DIV_TIMEOUT + 1);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic              div_start_q, div_start_d;
   logic              div_kill_q, div_kill_d;
   logic [XLEN-1:0]   div_dividend_q, div_dividend_d;
   logic [XLEN-1:0]   div_divisor_q, div_divisor_d;
   logic              div_is_unsign_q, div_is_unsign_d;
   logic              out_valid_q, out_valid_d;
   logic [XLEN-1:0]   out_data_q, out_data_d;
   logic [4:0]        out_rd_q, out_rd_d;
   logic              out_err_q, out_err_d;
   logic              rem_sel_q, rem_sel_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              accept_c;
   logic              div_zero_c;
   logic              ovf_c;
   logic              cache_hit_c;
   logic [XLEN-1:0]   cache_data_c;
   logic              local_c;
   logic [XLEN-1:0]   local_data_c;
   logic              timeout_c;

   // Flush in IDLE blocks acceptance for that cycle.
   assign accept_c   = (state_q == S_IDLE) && in_valid && !flush;
   assign div_zero_c = (in_rs2 == '0);
   assign ovf_c      = !in_op[0] && (in_rs1 == INT_MIN) && (in_rs2 == '1);
   assign local_c    = div_zero_c || ovf_c || cache_hit_c;
   assign timeout_c  = (cnt_q == CNT_W'(DIV_TIMEOUT));

   // Result for ops that never reach the core; op[1] selects remainder.
   always_comb begin
      local_data_c = cache_data_c;
      if (div_zero_c) begin
         local_data_c = in_op[1] ? in_rs1 : '1;
      end else if (ovf_c) begin
         local_data_c = in_op[1] ? '0 : INT_MIN;
      end
   end

`ifdef DIV_RESULT_CACHE_EN
   logic            launch_c, capture_c, tmo_c;
   logic            cache_vld_q, cache_vld_d;
   logic            cache_uns_q, cache_uns_d;
   logic [XLEN-1:0] cache_rs1_q, cache_rs1_d;
   logic [XLEN-1:0] cache_rs2_q, cache_rs2_d;
   logic [XLEN-1:0] cache_quo_q, cache_quo_d;
   logic [XLEN-1:0] cache_rem_q, cache_rem_d;

   assign launch_c  = accept_c && !local_c;
   assign capture_c = (state_q == S_BUSY) && !flush && div_done;
   assign tmo_c     = (state_q == S_BUSY) && !flush && !div_done && timeout_c;

   assign cache_hit_c  = cache_vld_q && (in_rs1 == cache_rs1_q) &&
                         (in_rs2 == cache_rs2_q) && (in_op[0] == cache_uns_q);
   assign cache_data_c = in_op[1] ? cache_rem_q : cache_quo_q;

   // Keep the last core result; invalidate on launch or watchdog abort.
   always_comb begin
      cache_vld_d = cache_vld_q;
      cache_uns_d = cache_uns_q;
      cache_rs1_d = cache_rs1_q;
      cache_rs2_d = cache_rs2_q;
      cache_quo_d = cache_quo_q;
      cache_rem_d = cache_rem_q;
      if (launch_c || tmo_c) begin
         cache_vld_d = 1'b0;
      end else if (capture_c) begin
         cache_vld_d = 1'b1;
         cache_uns_d = div_is_unsign_q;
         cache_rs1_d = div_dividend_q;
         cache_rs2_d = div_divisor_q;
         cache_quo_d = div_quotient;
         cache_rem_d = div_remainder;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cache_vld_q <= 1'b0;
         cache_uns_q <= 1'b0;
         cache_rs1_q <= '0;
         cache_rs2_q <= '0;
         cache_quo_q <= '0;
         cache_rem_q <= '0;
      end else begin
         cache_vld_q <= cache_vld_d;
         cache_uns_q <= cache_uns_d;
         cache_rs1_q <= cache_rs1_d;
         cache_rs2_q <= cache_rs2_d;
         cache_quo_q <= cache_quo_d;
         cache_rem_q <= cache_rem_d;
      end
   end
`else
   assign cache_hit_c  = 1'b0;
   assign cache_data_c = '0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; flush outranks div_done, timeout and out_ready.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               state_d = local_c ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (div_done || timeout_c) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (flush || out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Registered outputs and datapath.
   always_comb begin
      in_ready_d      = (state_d == S_IDLE);
      div_start_d     = 1'b0;
      div_kill_d      = 1'b0;
      div_dividend_d  = div_dividend_q;
      div_divisor_d   = div_divisor_q;
      div_is_unsign_d = div_is_unsign_q;
      out_valid_d     = out_valid_q;
      out_data_d      = out_data_q;
      out_rd_d        = out_rd_q;
      out_err_d       = out_err_q;
      rem_sel_d       = rem_sel_q;
      cnt_d           = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               rem_sel_d = in_op[1];
               out_rd_d  = in_rd;
               out_err_d = 1'b0;
               if (local_c) begin
                  out_valid_d = 1'b1;
                  out_data_d  = local_data_c;
               end else begin
                  div_start_d     = 1'b1;
                  div_dividend_d  = in_rs1;
                  div_divisor_d   = in_rs2;
                  div_is_unsign_d = in_op[0];
                  cnt_d           = '0;
               end
            end
         end
         S_BUSY: begin
            // Counter reads 0 in the div_start cycle.
            cnt_d = cnt_q + CNT_W'(1);
            if (flush) begin
               div_kill_d = 1'b1;
            end else if (div_done) begin
               out_valid_d = 1'b1;
               out_data_d  = rem_sel_q ? div_remainder : div_quotient;
            end else if (timeout_c) begin
               div_kill_d  = 1'b1;
               out_valid_d = 1'b1;
               out_err_d   = 1'b1;
               out_data_d  = '0;
            end
         end
         S_DONE: begin
            if (flush || out_ready) begin
               out_valid_d = 1'b0;
               out_err_d   = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready_q      <= 1'b1;
         div_start_q     <= 1'b0;
         div_kill_q      <= 1'b0;
         div_dividend_q  <= '0;
         div_divisor_q   <= '0;
         div_is_unsign_q <= 1'b0;
         out_valid_q     <= 1'b0;
         out_data_q      <= '0;
         out_rd_q        <= '0;
         out_err_q       <= 1'b0;
         rem_sel_q       <= 1'b0;
         cnt_q           <= '0;
      end else begin
         in_ready_q      <= in_ready_d;
         div_start_q     <= div_start_d;
         div_kill_q      <= div_kill_d;
         div_dividend_q  <= div_dividend_d;
         div_divisor_q   <= div_divisor_d;
         div_is_unsign_q <= div_is_unsign_d;
         out_valid_q     <= out_valid_d;
         out_data_q      <= out_data_d;
         out_rd_q        <= out_rd_d;
         out_err_q       <= out_err_d;
         rem_sel_q       <= rem_sel_d;
         cnt_q           <= cnt_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign div_start     = div_start_q;
   assign div_kill      = div_kill_q;
   assign div_dividend  = div_dividend_q;
   assign div_divisor   = div_divisor_q;
   assign div_is_unsign = div_is_unsign_q;
   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;
   assign out_rd        = out_rd_q;
   assign out_err       = out_err_q;

endmodule
